secded_decoder_pipe: RTL
========================

SECDED_DECODER_PIPE -- requirements
Module: secded_decoder_pipe

Interface
REQ-001 SHALL have parameter DAT_WIDTH, default 128, meaning data bits per word (legal range 8..247).
REQ-002 SHALL have parameter ECC_WIDTH, default 9, meaning check bits per word; must satisfy 2^(ECC_WIDTH-1) >= DAT_WIDTH+ECC_WIDTH.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, meaning error-counter width.
REQ-004 SHALL use one clock, clk; reset rst_n is asynchronous and active-low.
REQ-005 Ports: clk in 1, rising-edge clock; rst_n in 1, async active-low reset.
REQ-006 Ports: in_valid in 1; in_ready out 1; data_in in DAT_WIDTH; ecc_in in ECC_WIDTH.
REQ-007 Ports: out_valid out 1; out_ready in 1; corrected_out out DAT_WIDTH; single_error out 1; double_error out 1; fault_error out 1; syndrome_out out ECC_WIDTH.
REQ-008 Ports: cnt_clr in 1; single_cnt out CNT_WIDTH; double_cnt out CNT_WIDTH; log_clr in 1; err_log_valid out 1; err_log_syndrome out ECC_WIDTH; irq out 1.

Function
REQ-009 Data bit j SHALL map to codeword position p_j, the (j+1)-th integer >=3 that is not a power of two.
REQ-010 Computed check bit k (1..ECC_WIDTH-1) SHALL be the XOR of data bits j with bit (k-1) of p_j set; check bit 0 is overall parity over data and check bits 1..ECC_WIDTH-1.
REQ-011 syndrome = computed ^ ecc_in; h = syndrome[ECC_WIDTH-1:1]; p = XOR of all data_in and ecc_in bits.
REQ-012 Classification: h=0,p=0 -> clean; p=1 and h=0, or h a power of two -> single_error, data unchanged; p=1 and h=p_j -> single_error, flip data bit j; p=0,h!=0 -> double_error; p=1 and h matches no position -> fault_error.
REQ-013 At most one of single_error/double_error/fault_error SHALL be high per output word; flags qualify only while out_valid=1.
REQ-014 Pipeline SHALL be two stages: stage 1 registers data and syndrome, stage 2 registers corrected data and flags; latency exactly 2 cycles without backpressure.
REQ-015 Advance enable en = !out_valid || out_ready; in_ready = en; both stages hold all contents while en=0.
REQ-016 Word accepted when in_valid&&in_ready; output consumed when out_valid&&out_ready; full throughput of one word per cycle at out_ready=1.
REQ-017 Bubbles (in_valid=0 while en=1) SHALL propagate as out_valid=0; no word is dropped or duplicated under any out_ready pattern.
REQ-018 err_log SHALL capture syndrome_out of the first double or fault word consumed while err_log_valid=0, then hold until log_clr.
REQ-019 log_clr in the same cycle as a qualifying consume SHALL leave err_log_valid=1 holding the new syndrome.
REQ-020 irq SHALL equal err_log_valid.

Reset
REQ-021 On rst_n=0 SHALL asynchronously clear: both stage valids, out_valid=0, all flags 0, corrected_out=0, syndrome_out=0, counters 0, err_log_valid=0, err_log_syndrome=0; in_ready=1 once out_valid=0.
REQ-022 Reset mid-stream SHALL discard in-flight words; first post-reset output appears 2 cycles after the first accepted word.

Configuration
REQ-023 With macro SECDED_ERR_CNT_EN defined: single_cnt/double_cnt increment on each consumed word with single_error/double_error, saturate at all-ones, clear on cnt_clr; cnt_clr with a concurrent event loads 1.
REQ-024 Without SECDED_ERR_CNT_EN: counter logic absent, single_cnt and double_cnt tied to 0, cnt_clr ignored; all other behaviour identical.

Verification
REQ-025 Clean stream: 8 random words with matching ecc, out_ready=1 -> 8 outputs, cycle n+2, data identical, all flags 0.
REQ-026 Single data flip: bit 127 of encoded word inverted -> corrected_out equals original, single_error=1, single_cnt=1 (macro on).
REQ-027 Double flip: data bits 0 and 5 inverted -> double_error=1, err_log_valid=1, irq=1, err_log_syndrome=syndrome_out; second double error leaves log unchanged.
REQ-028 Backpressure: out_ready toggled 1,0,0,1 pseudo-randomly over 100 words -> in-order, lossless output, in_ready low whenever out_valid=1 and out_ready=0.
REQ-029 Saturation/clear: CNT_WIDTH=2, 5 single errors -> single_cnt=3; cnt_clr with a concurrent single error -> single_cnt=1; macro off -> counters stay 0.
REQ-030 Reset mid-operation: rst_n low with 2 words in flight -> out_valid=0 immediately, counters and log 0, no stale word emitted afterward.

Source files
------------

// File: rtl/secded_decoder_pipe.sv
// secded_decoder_pipe: two-stage SECDED (Hamming + overall parity) decoder
// with valid/ready flow control, a sticky first-error syndrome log and
// optional saturating error counters.
// Optional feature macro: SECDED_ERR_CNT_EN enables single_cnt/double_cnt;
// without it both counters read 0 and cnt_clr is ignored.
module secded_decoder_pipe #(
    parameter int DAT_WIDTH = 128,
    parameter int ECC_WIDTH = 9,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DAT_WIDTH-1:0] data_in,
    input  logic [ECC_WIDTH-1:0] ecc_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DAT_WIDTH-1:0] corrected_out,
    output logic                 single_error,
    output logic                 double_error,
    output logic                 fault_error,
    output logic [ECC_WIDTH-1:0] syndrome_out,
    input  logic                 cnt_clr,
    output logic [CNT_WIDTH-1:0] single_cnt,
    output logic [CNT_WIDTH-1:0] double_cnt,
    input  logic                 log_clr,
    output logic                 err_log_valid,
    output logic [ECC_WIDTH-1:0] err_log_syndrome,
    output logic                 irq
);

    localparam int HW = ECC_WIDTH - 1;

    // Codeword position of data bit j: the (j+1)-th integer >= 3 that is not a power of two.
    function automatic int pos_of(input int j);
        int cnt;
        int res;
        cnt = 0;
        res = 0;
        for (int q = 3; q < (1 << ECC_WIDTH); q++) begin
            if ((q & (q - 1)) != 0) begin
                if (cnt == j) res = q;
                cnt++;
                if (cnt > j) break;
            end
        end
        return res;
    endfunction

    // Data bits covered by Hamming check bit k (k >= 1).
    function automatic logic [DAT_WIDTH-1:0] chk_mask(input int k);
        logic [DAT_WIDTH-1:0] m;
        int p;
        m = '0;
        for (int j = 0; j < DAT_WIDTH; j++) begin
            p = pos_of(j);
            m[j] = p[k-1];
        end
        return m;
    endfunction

    logic                 w_en;
    logic [HW-1:0]        w_hchk;
    logic [ECC_WIDTH-1:0] w_calc;
    logic [ECC_WIDTH-1:0] w_syn;
    logic                 w_par;

    logic                 r_vld_p1;
    logic [DAT_WIDTH-1:0] r_data_p1;
    logic [ECC_WIDTH-1:0] r_syn_p1;
    logic                 r_par_p1;

    logic [HW-1:0]        w_h;
    logic [DAT_WIDTH-1:0] w_flip;
    logic                 w_h_zero;
    logic                 w_h_pow2;
    logic                 w_any_flip;
    logic                 w_single;
    logic                 w_double;
    logic                 w_fault;

    logic                 r_vld_p2;
    logic [DAT_WIDTH-1:0] r_data_p2;
    logic [ECC_WIDTH-1:0] r_syn_p2;
    logic                 r_single_p2;
    logic                 r_double_p2;
    logic                 r_fault_p2;

    logic                 w_consume;
    logic                 w_log_evt;
    logic                 r_log_vld;
    logic [ECC_WIDTH-1:0] r_log_syn;

    // Both stages advance together; a stalled output freezes the whole pipe.
    assign w_en     = !r_vld_p2 || out_ready;
    assign in_ready = w_en;

    // ---- stage 0 -> 1: syndrome and overall parity from the raw word ----
    for (genvar k = 1; k < ECC_WIDTH; k++) begin : g_chk
        localparam logic [DAT_WIDTH-1:0] MASK = chk_mask(k);
        assign w_hchk[k-1] = ^(data_in & MASK);
    end
    assign w_calc = {w_hchk, ^{data_in, w_hchk}};
    assign w_syn  = w_calc ^ ecc_in;
    assign w_par  = ^{data_in, ecc_in};

    // Stage 1 register: raw data, syndrome and received-word parity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1  <= 1'b0;
            r_data_p1 <= '0;
            r_syn_p1  <= '0;
            r_par_p1  <= 1'b0;
        end else if (w_en) begin
            r_vld_p1  <= in_valid;
            r_data_p1 <= data_in;
            r_syn_p1  <= w_syn;
            r_par_p1  <= w_par;
        end
    end

    // ---- stage 1 -> 2: classify syndrome and correct data ----
    assign w_h = r_syn_p1[ECC_WIDTH-1:1];
    for (genvar j = 0; j < DAT_WIDTH; j++) begin : g_pos
        localparam logic [HW-1:0] POS_H = HW'(pos_of(j));
        assign w_flip[j] = r_par_p1 && (w_h == POS_H);
    end
    assign w_h_zero   = (w_h == '0);
    assign w_h_pow2   = !w_h_zero && ((w_h & (w_h - HW'(1))) == '0);
    assign w_any_flip = |w_flip;
    // A power-of-two h or h=0 with odd parity means a check bit flipped: data is intact.
    assign w_single   = r_par_p1 && (w_h_zero || w_h_pow2 || w_any_flip);
    assign w_double   = !r_par_p1 && !w_h_zero;
    assign w_fault    = r_par_p1 && !w_h_zero && !w_h_pow2 && !w_any_flip;

    // Stage 2 register: corrected word and flags, flags forced low on bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p2    <= 1'b0;
            r_data_p2   <= '0;
            r_syn_p2    <= '0;
            r_single_p2 <= 1'b0;
            r_double_p2 <= 1'b0;
            r_fault_p2  <= 1'b0;
        end else if (w_en) begin
            r_vld_p2    <= r_vld_p1;
            r_data_p2   <= r_data_p1 ^ w_flip;
            r_syn_p2    <= r_syn_p1;
            r_single_p2 <= r_vld_p1 && w_single;
            r_double_p2 <= r_vld_p1 && w_double;
            r_fault_p2  <= r_vld_p1 && w_fault;
        end
    end

    assign out_valid     = r_vld_p2;
    assign corrected_out = r_data_p2;
    assign syndrome_out  = r_syn_p2;
    assign single_error  = r_single_p2;
    assign double_error  = r_double_p2;
    assign fault_error   = r_fault_p2;

    assign w_consume = r_vld_p2 && out_ready;
    assign w_log_evt = w_consume && (r_double_p2 || r_fault_p2);

    // Sticky log of the first uncorrectable syndrome; a clear coinciding with a new event re-arms with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_log_vld <= 1'b0;
            r_log_syn <= '0;
        end else if (log_clr) begin
            r_log_vld <= w_log_evt;
            r_log_syn <= w_log_evt ? r_syn_p2 : '0;
        end else if (w_log_evt && !r_log_vld) begin
            r_log_vld <= 1'b1;
            r_log_syn <= r_syn_p2;
        end
    end

    assign err_log_valid    = r_log_vld;
    assign err_log_syndrome = r_log_syn;
    assign irq              = r_log_vld;

`ifdef SECDED_ERR_CNT_EN
    logic [CNT_WIDTH-1:0] r_single_cnt;
    logic [CNT_WIDTH-1:0] r_double_cnt;
    logic                 w_single_evt;
    logic                 w_double_evt;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (&c) ? c : c + CNT_WIDTH'(1);
    endfunction

    assign w_single_evt = w_consume && r_single_p2;
    assign w_double_evt = w_consume && r_double_p2;

    // Saturating event counters; a clear in the same cycle as an event counts that event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_single_cnt <= '0;
            r_double_cnt <= '0;
        end else begin
            if (cnt_clr)           r_single_cnt <= w_single_evt ? CNT_WIDTH'(1) : '0;
            else if (w_single_evt) r_single_cnt <= sat_inc(r_single_cnt);
            if (cnt_clr)           r_double_cnt <= w_double_evt ? CNT_WIDTH'(1) : '0;
            else if (w_double_evt) r_double_cnt <= sat_inc(r_double_cnt);
        end
    end

    assign single_cnt = r_single_cnt;
    assign double_cnt = r_double_cnt;
`else
    logic w_unused_cnt_clr;
    assign w_unused_cnt_clr = cnt_clr;
    assign single_cnt       = '0;
    assign double_cnt       = '0;
`endif

endmodule
